// File: rtl/button_debouncer.sv
// Debounces N_BTN raw push-button inputs into clean levels plus single-cycle
// press, release and long-press pulses, all sampled on a shared prescaler tick.
module button_debouncer #(
   parameter int unsigned CLK_FREQ         = 50_000_000,
   parameter int unsigned SAMPLE_HZ        = 1000,
   parameter int unsigned DEBOUNCE_SAMPLES = 20,
   parameter int unsigned LONG_PRESS_MS    = 1000,
   parameter int unsigned N_BTN            = 4,
   parameter int unsigned BTN_ACTIVE_LOW   = 1
) (
   input  logic             clk_50mhz,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long,
   output logic             sample_tick
);

   localparam int unsigned CNT_MAX    = CLK_FREQ / SAMPLE_HZ;
   localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned DEB_W      = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
   localparam int unsigned LONG_TICKS = LONG_PRESS_MS * SAMPLE_HZ / 1000;
   localparam int unsigned HOLD_W     = $clog2(LONG_TICKS + 1);
   localparam logic [N_BTN-1:0] IDLE_RAW = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [N_BTN-1:0]  sync1;
   logic [N_BTN-1:0]  sync2;
   logic [N_BTN-1:0]  s;
   logic [N_BTN-1:0]  flip;
   logic [N_BTN-1:0]  long_fired;
   logic [CNT_W-1:0]  cnt;
   logic [DEB_W-1:0]  deb_cnt  [N_BTN];
   logic [HOLD_W-1:0] hold_cnt [N_BTN];

   always_comb begin
      s    = (BTN_ACTIVE_LOW != 0) ? ~sync2 : sync2;
      flip = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         flip[i] = sample_tick && (s[i] != btn_level[i]) &&
                   (deb_cnt[i] == DEB_W'(DEBOUNCE_SAMPLES - 1));
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         sync1       <= IDLE_RAW;
         sync2       <= IDLE_RAW;
         cnt         <= '0;
         sample_tick <= 1'b0;
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         btn_long    <= '0;
         long_fired  <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            deb_cnt[i]  <= '0;
            hold_cnt[i] <= '0;
         end
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
         if (cnt == CNT_W'(CNT_MAX - 1)) begin
            cnt         <= '0;
            sample_tick <= 1'b1;
         end else begin
            cnt         <= cnt + 1'b1;
            sample_tick <= 1'b0;
         end
         btn_press   <= '0;
         btn_release <= '0;
         btn_long    <= '0;
         if (sample_tick) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
               if (s[i] == btn_level[i]) begin
                  deb_cnt[i] <= '0;
               end else if (flip[i]) begin
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
               // A confirmed edge restarts hold tracking and takes priority over a long pulse on the same tick
               if (flip[i]) begin
                  btn_level[i]   <= ~btn_level[i];
                  btn_press[i]   <= s[i];
                  btn_release[i] <= ~s[i];
                  hold_cnt[i]    <= '0;
                  long_fired[i]  <= 1'b0;
               end else if (btn_level[i] && !long_fired[i]) begin
                  if (hold_cnt[i] == HOLD_W'(LONG_TICKS - 1)) begin
                     hold_cnt[i]   <= HOLD_W'(LONG_TICKS);
                     btn_long[i]   <= 1'b1;
                     long_fired[i] <= 1'b1;
                  end else begin
                     hold_cnt[i] <= hold_cnt[i] + 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed plus randomized bench for button_debouncer; every cycle is compared
// against a tick-count based reference model of the debounce rules.
module tb_button_debouncer;

   localparam int DEB  = 4;
   localparam int LONG = 10;
   localparam int PER  = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn = 4'hF;
   logic [3:0] btn_level, btn_press, btn_release, btn_long;
   logic       sample_tick;

   int checks = 0;
   int failures = 0;

   button_debouncer #(
      .CLK_FREQ(1000), .SAMPLE_HZ(100), .DEBOUNCE_SAMPLES(4),
      .LONG_PRESS_MS(100), .N_BTN(4), .BTN_ACTIVE_LOW(1)
   ) dut (
      .clk_50mhz(clk), .rst(rst), .btn_in(btn), .btn_level(btn_level),
      .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long),
      .sample_tick(sample_tick)
   );

   always #5 clk = ~clk;

   // reference model: edges since reset release, raw history, per-channel run lengths
   int         edges;
   logic [3:0] raw_d1, raw_d2;
   int         run [4];
   int         held [4];
   bit         fired [4];
   logic [3:0] e_level, e_press, e_rel, e_long;
   logic       e_tick;

   int n_press [4];
   int n_rel [4];
   int n_long [4];
   int n_tick = 0;
   int since_rst = 0;
   int last_tick = 0;
   bit seen_both = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit tick_eval;
      if (rst) begin
         edges = 0; raw_d1 = 4'hF; raw_d2 = 4'hF;
         e_level = '0; e_press = '0; e_rel = '0; e_long = '0; e_tick = 0;
         for (int i = 0; i < 4; i++) begin run[i] = 0; held[i] = 0; fired[i] = 0; end
         return;
      end
      tick_eval = (edges > 0) && (edges % PER == 0);
      e_press = '0; e_rel = '0; e_long = '0;
      if (tick_eval) begin
         for (int i = 0; i < 4; i++) begin
            bit pressed_now;
            bit was;
            pressed_now = !raw_d2[i];
            was = e_level[i];
            run[i] = (pressed_now != was) ? run[i] + 1 : 0;
            if (run[i] == DEB) begin
               run[i] = 0;
               e_level[i] = !was;
               if (pressed_now) e_press[i] = 1'b1; else e_rel[i] = 1'b1;
               held[i] = 0; fired[i] = 0;
            end else if (was && !fired[i]) begin
               held[i]++;
               if (held[i] == LONG) begin e_long[i] = 1'b1; fired[i] = 1; end
            end
         end
      end
      raw_d2 = raw_d1; raw_d1 = btn;
      edges++;
      e_tick = (edges % PER == 0);
   endtask

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge();
         if (rst) begin since_rst = 0; last_tick = 0; end else since_rst++;
         #1;
         chk("outputs", {15'd0, btn_level, btn_press, btn_release, btn_long, sample_tick},
             {15'd0, e_level, e_press, e_rel, e_long, e_tick});
         for (int i = 0; i < 4; i++) begin
            n_press[i] += int'(btn_press[i]);
            n_rel[i]   += int'(btn_release[i]);
            n_long[i]  += int'(btn_long[i]);
         end
         if (btn_press[0] && btn_press[3]) seen_both = 1;
         if (sample_tick) begin
            n_tick++;
            chk("tick_period", since_rst - last_tick, PER);
            last_tick = since_rst;
         end
      end
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 4; i++) begin n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; end
      // 1: reset with all buttons idle, quiet for 200 cycles
      cyc(3);
      chk("reset_outputs", {btn_level, btn_press, btn_release, btn_long, sample_tick}, 0);
      rst = 0;
      cyc(200);
      chk("t1_ticks", n_tick, 20);
      chk("t1_no_events", n_press[0] + n_press[1] + n_press[2] + n_press[3] + n_long[0] + n_rel[0], 0);
      // 2: clean press on channel 0
      btn[0] = 0;
      cyc(43);
      chk("t2_press0", n_press[0], 1);
      chk("t2_others", n_press[1] + n_press[2] + n_press[3], 0);
      chk("t2_level", btn_level, 4'b0001);
      // 3: bounce on channel 1 (3 ticks low, 1 tick high), random phase
      cyc($urandom_range(0, 9));
      for (int p = 0; p < 5; p++) begin
         btn[1] = 0; cyc(30);
         btn[1] = 1; cyc(10);
      end
      chk("t3_no_press", n_press[1], 0);
      chk("t3_level", btn_level[1], 0);
      btn[1] = 0;
      cyc(43);
      chk("t3_press", n_press[1], 1);
      // 4: long press on channel 2
      btn[2] = 0;
      cyc(43);
      chk("t4_press", n_press[2], 1);
      chk("t4_no_long_yet", n_long[2], 0);
      cyc(105);
      chk("t4_long", n_long[2], 1);
      cyc(200 + $urandom_range(0, 50));
      chk("t4_single_long", n_long[2], 1);
      btn[2] = 1;
      cyc(50);
      chk("t4_release", n_rel[2], 1);
      btn[2] = 0; cyc(50);
      btn[2] = 1; cyc(60);
      chk("t4_second_press", n_press[2], 2);
      chk("t4_no_second_long", n_long[2], 1);
      chk("t4_second_release", n_rel[2], 2);
      // 5: simultaneous press on channels 0 and 3
      btn[1:0] = 2'b11;
      cyc(50);
      btn[0] = 0; btn[3] = 0;
      cyc(50);
      chk("t5_same_cycle", seen_both, 1);
      chk("t5_press3", n_press[3], 1);
      // 6: reset after three differing ticks discards the pending press
      btn = 4'hF;
      cyc(50);
      found = 0;
      for (int k = 0; k < 12 && !found; k++) begin
         cyc(1);
         if (sample_tick) found = 1;
      end
      chk("t6_tick_found", found, 1);
      btn[0] = 0;
      cyc(32);
      chk("t6_pending", btn_level[0], 0);
      rst = 1;
      cyc(1);
      chk("t6_reset_outputs", {btn_level, btn_press, btn_release, btn_long, sample_tick}, 0);
      rst = 0;
      cyc(40);
      chk("t6_not_yet", btn_level[0], 0);
      cyc(1);
      chk("t6_fresh_press", btn_press[0], 1);
      // randomized traffic with one mid-run reset
      for (int k = 0; k < 2500; k++) begin
         if ($urandom_range(0, 59) == 0) btn = btn ^ 4'($urandom);
         rst = (k == 1300);
         cyc(1);
      end
      rst = 0;
      cyc(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
